// File: rtl/cache_sim_pkg.sv
// cache_sim_pkg: trace command codes, channel op encodings and dispatcher FSM states
package cache_sim_pkg;
    typedef enum logic [3:0] {
        CMD_DR    = 4'd0,
        CMD_DW    = 4'd1,
        CMD_IR    = 4'd2,
        CMD_INV   = 4'd3,
        CMD_RD    = 4'd4,
        CMD_WR    = 4'd5,
        CMD_RWIM  = 4'd6,
        CMD_CLEAR = 4'd8,
        CMD_PRINT = 4'd9
    } trace_cmd_e;
    typedef enum logic [1:0] {L1_DR, L1_DW, L1_IR} l1_op_e;
    typedef enum logic [1:0] {SNP_INV, SNP_RD, SNP_WR, SNP_RWIM} snp_op_e;
    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_ISSUE} disp_state_e;
    localparam int STAT_IDX_ILLEGAL = 10;
    localparam int NUM_STATS = 11;
endpackage

// File: rtl/dispatch_fifo.sv
// dispatch_fifo: show-ahead FIFO with full/empty flags; head reads 0 while empty
module dispatch_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;
    assign o_full  = r_cnt == (AW+1)'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = o_empty ? '0 : r_mem[r_rd];
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            r_wr  <= r_wr + AW'(w_push);
            r_rd  <= r_rd + AW'(w_pop);
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    always_ff @(posedge clk)
        if (w_push) r_mem[r_wr] <= i_data;
endmodule

// File: rtl/trace_dispatcher.sv
// trace_dispatcher: routes trace records to L1/snoop FIFOs; clear/print drain both before pulsing.
// Define TRACE_STATS_EN to add saturating per-command accept counters readable via stat_sel.
module trace_dispatcher
    import cache_sim_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_cmd,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              l1_valid,
    input  logic              l1_ready,
    output logic [1:0]        l1_op,
    output logic [ADDR_W-1:0] l1_addr,
    output logic              snp_valid,
    input  logic              snp_ready,
    output logic [1:0]        snp_op,
    output logic [ADDR_W-1:0] snp_addr,
    output logic              clr_pulse,
    output logic              prt_pulse,
    output logic              err_pulse,
    input  logic [3:0]        stat_sel,
    output logic [CNT_W-1:0]  stat_cnt
);
    localparam int FW = 2 + ADDR_W;
    disp_state_e r_state, w_next;
    logic        r_kind_prt;
    logic        r_err;
    logic        w_acc, w_is_l1, w_is_snp, w_is_bar, w_ill;
    logic        w_l1_full, w_l1_empty, w_snp_full, w_snp_empty;
    l1_op_e      w_l1_op;
    snp_op_e     w_snp_op;
    logic [FW-1:0] w_l1_data, w_snp_data;
    assign w_is_l1  = in_cmd <= 4'd2;
    assign w_is_snp = in_cmd >= 4'd3 && in_cmd <= 4'd6;
    assign w_is_bar = in_cmd == CMD_CLEAR || in_cmd == CMD_PRINT;
    assign w_ill    = !(w_is_l1 || w_is_snp || w_is_bar);
    assign in_ready = r_state == ST_RUN && !w_l1_full && !w_snp_full;
    assign w_acc    = in_valid && in_ready;
    assign w_l1_op  = l1_op_e'(in_cmd[1:0]);
    // Snoop codes 3..6 map to ops 0..3 by subtracting 3 modulo 4
    assign w_snp_op = snp_op_e'(in_cmd[1:0] - 2'd3);
    dispatch_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_l1_fifo (
        .clk(clk), .reset(reset),
        .i_push(w_acc && w_is_l1), .i_data({w_l1_op, in_addr}),
        .i_pop(l1_ready), .o_data(w_l1_data),
        .o_full(w_l1_full), .o_empty(w_l1_empty)
    );
    dispatch_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_snp_fifo (
        .clk(clk), .reset(reset),
        .i_push(w_acc && w_is_snp), .i_data({w_snp_op, in_addr}),
        .i_pop(snp_ready), .o_data(w_snp_data),
        .o_full(w_snp_full), .o_empty(w_snp_empty)
    );
    assign {l1_op, l1_addr}   = w_l1_data;
    assign {snp_op, snp_addr} = w_snp_data;
    assign l1_valid  = !w_l1_empty;
    assign snp_valid = !w_snp_empty;
    assign err_pulse = r_err;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_state    <= ST_RUN;
            r_kind_prt <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_acc && w_ill;
            if (w_acc && w_is_bar) r_kind_prt <= in_cmd == CMD_PRINT;
        end
    always_comb begin
        w_next    = r_state;
        clr_pulse = 1'b0;
        prt_pulse = 1'b0;
        case (r_state)
            ST_RUN:   w_next = (w_acc && w_is_bar) ? ST_DRAIN : ST_RUN;
            ST_DRAIN: w_next = (w_l1_empty && w_snp_empty) ? ST_ISSUE : ST_DRAIN;
            default: begin
                w_next    = ST_RUN;
                clr_pulse = !r_kind_prt;
                prt_pulse = r_kind_prt;
            end
        endcase
    end
`ifdef TRACE_STATS_EN
    logic [CNT_W-1:0] r_stat [NUM_STATS];
    logic [3:0]       w_stat_idx;
    assign w_stat_idx = w_ill ? 4'(STAT_IDX_ILLEGAL) : in_cmd;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            for (int i = 0; i < NUM_STATS; i++) r_stat[i] <= '0;
        end else if (w_acc && r_stat[w_stat_idx] != '1) begin
            r_stat[w_stat_idx] <= r_stat[w_stat_idx] + CNT_W'(1);
        end
    assign stat_cnt = (stat_sel < 4'(NUM_STATS)) ? r_stat[stat_sel] : '0;
`else
    logic w_unused_sel;
    assign w_unused_sel = ^stat_sel;
    assign stat_cnt     = '0;
`endif
endmodule

// File: doc/trace_dispatcher.md
# trace_dispatcher

Synthesizable, parametrised successor to the trace-driven stimulus front end of the L2 cache simulator. Accepts decoded trace records (command, address) over a valid/ready handshake and routes them into two buffered output channels: L1 requests (data read, data write, instruction read) and snooped bus operations (invalidate, read, write, RWIM). Clear (8) and print (9) act as ordering barriers: both channels drain before a one-cycle control pulse issues. Optional per-command statistics counters.

## Interface
- ADDR_W, 32, trace address width
- FIFO_DEPTH, 4, entries per channel FIFO; power of two, ≥2
- CNT_W, 32, statistics counter width
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid / in_ready  in / out  1  trace record handshake
- in_cmd  in  4  trace command code 0–15
- in_addr  in  ADDR_W  trace address
- l1_valid / l1_ready  out / in  1  L1 channel handshake
- l1_op  out  2  0=DR, 1=DW, 2=IR
- l1_addr  out  ADDR_W  L1 request address
- snp_valid / snp_ready  out / in  1  snoop channel handshake
- snp_op  out  2  0=INV, 1=RD, 2=WR, 3=RWIM
- snp_addr  out  ADDR_W  snoop address
- clr_pulse  out  1  one-cycle clear-cache/reset-states request
- prt_pulse  out  1  one-cycle print-valid-lines request
- err_pulse  out  1  one-cycle illegal-command flag
- stat_sel  in  4  counter select (0–9 = command, 10 = illegal)
- stat_cnt  out  CNT_W  selected counter value

## Operation
- Decode: 0→L1 DR, 1→L1 DW, 2→L1 IR, 3→snp INV, 4→snp RD, 5→snp WR, 6→snp RWIM, 8→clear barrier, 9→print barrier; 7 and 10–15 illegal.
- Accept when in_valid && in_ready. in_ready = (state==RUN) && !l1_full && !snp_full; no combinational path from in_cmd or in_valid.
- L1/snoop commands push {op, addr} into their channel FIFO. Show-ahead FIFOs: *_valid = !empty, op/addr = head; pop on *_valid && *_ready.
- Channels independent; either may stall without blocking the other's drain. Order preserved within a channel.
- Illegal command: accepted, dropped, err_pulse high the following cycle.
- FSM states RUN, DRAIN, ISSUE. RUN: accept 8/9 → DRAIN, latch kind. DRAIN: when both FIFOs empty → ISSUE. ISSUE: clr_pulse or prt_pulse high (decoded from state register) → RUN. in_ready low in DRAIN and ISSUE.
- Reset: FIFOs empty, state RUN, all pulses 0, *_valid 0, in_ready 1 after release, counters 0, op/addr outputs 0.
- Reset mid-drain abandons the barrier; no pulse issued.

## Timing
- Accept at cycle N → *_valid at N+1 (if FIFO was empty). Full FIFO → in_ready low same cycle the last entry is written (next cycle).
- Push and pop same cycle on one FIFO: count unchanged; permitted at any non-full occupancy.
- Barrier with both FIFOs empty at N: DRAIN N+1, ISSUE (pulse) N+2, in_ready high N+3.
- Barrier with occupied FIFOs: pulse exactly one cycle after the cycle in which both FIFOs are observed empty.
- err_pulse at N+1 for illegal accept at N; independent of channel state.
- Pointers wrap modulo FIFO_DEPTH; occupancy counter log2(FIFO_DEPTH)+1 bits.

## Configuration
- TRACE_STATS_EN defined: eleven CNT_W counters, incremented on accept of the corresponding command (illegal shared into index 10), saturate at all-ones; stat_cnt = counter[stat_sel] combinationally; stat_sel 11–15 reads 0.
- Undefined: no counters instantiated; stat_cnt tied to 0; all other behaviour identical.

## Structure
- Package cache_sim_pkg: trace command enum (CMD_DR…CMD_PRINT), l1_op_e, snp_op_e, dispatch FSM state enum, STAT_IDX_ILLEGAL constant.
- Sub-module dispatch_fifo (parametrised width/depth, show-ahead, full/empty), instantiated twice.

## Test plan
- Reset, then cmds 0,1,2 at 0x10,0x20,0x30 with l1_ready=1 → l1 ops DR,DW,IR, addrs 0x10,0x20,0x30 on consecutive cycles, one cycle after each accept.
- snp_ready=0, push 5 snoop cmds (FIFO_DEPTH=4) → in_ready low after 4th; raise snp_ready → remaining record accepted, order INV,RD,WR,RWIM,INV preserved.
- Two L1 records queued, l1_ready=0, then cmd 8 → in_ready low, no clr_pulse; release l1_ready → clr_pulse exactly once, one cycle after FIFO empty, then in_ready=1.
- cmd 9 with empty FIFOs at cycle N → prt_pulse at N+2, in_ready at N+3.
- cmd 7 and cmd 15 → err_pulse each, no channel activity; with TRACE_STATS_EN, stat_sel=10 reads 2.
- Assert reset during DRAIN with full snoop FIFO → outputs clear asynchronously, no clr_pulse, counters 0, in_ready 1 after release.
